// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI responder with oversampled inputs, modes 0-3, 8/16/24/32-bit words
module spi_slave_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        GCLK,
    input  logic        RST,
    input  logic [1:0]  spi_mode_i,
    input  logic [1:0]  word_len_i,
    input  logic [31:0] tx_data_i,
    output logic        tx_load_o,
    output logic [31:0] rx_data_o,
    output logic        rx_valid_o,
    output logic        frame_err_o,
    output logic        busy_o,
    input  logic        SCLK_i,
    input  logic        CS_i,
    input  logic        MOSI_i,
    output logic        MISO_o
);

    localparam logic [1:0] ST_ARM_WAIT = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_hist_q, cs_hist_q;

    logic [1:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] tx_sh_q, tx_sh_d;
    logic [31:0] rx_sh_q, rx_sh_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        first_q, first_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_load_q, tx_load_d;
    logic        frame_err_q, frame_err_d;

    logic        sclk_s, cs_s, mosi_s;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic        lead_edge, trail_edge, sample_edge, drive_edge;
    logic [5:0]  nbits, cnt_inc;
    logic [4:0]  msb_idx;
    logic [31:0] word_mask;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;

    // Edge roles follow the mode latched at CS fall: CPOL picks lead, CPHA picks sample
    assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
    assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
    assign drive_edge  = mode_q[0] ? lead_edge : trail_edge;

    assign nbits     = 6'd8 + {1'b0, len_q, 3'b000};
    assign cnt_inc   = bit_cnt_q + 6'd1;
    assign msb_idx   = 5'(nbits - 6'd1);
    assign word_mask = 32'hFFFF_FFFF >> (6'd32 - nbits);

    assign tx_load_o   = tx_load_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q == ST_ACTIVE);
    assign MISO_o      = (state_q == ST_ACTIVE) & tx_sh_q[msb_idx];

    // Input synchronisers plus one history stage for edge detection
    always_ff @(posedge GCLK) begin
        if (!RST) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI_i};
            sclk_hist_q <= sclk_s;
            cs_hist_q   <= cs_s;
        end
    end

    // Frame state machine, shifters and one-cycle status pulses
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        bit_cnt_d   = bit_cnt_q;
        first_d     = first_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_ARM_WAIT: begin
                if (cs_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    mode_d    = spi_mode_i;
                    len_d     = word_len_i;
                    tx_sh_d   = tx_data_i;
                    tx_load_d = 1'b1;
                    bit_cnt_d = 6'd0;
                    // With CPHA=0 the MSB is already on the line, so the first drive
                    // edge must advance; only CPHA=1 skips its opening drive edge.
                    first_d   = spi_mode_i[0];
                    state_d   = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    // CS rise wins over a coincident sample edge
                    if (bit_cnt_q != 6'd0) frame_err_d = 1'b1;
                    bit_cnt_d = 6'd0;
                    state_d   = ST_IDLE;
                end else if (sample_edge) begin
                    rx_sh_d = (rx_sh_q << 1) | {31'd0, mosi_s};
                    if (cnt_inc == nbits) begin
                        rx_data_d  = rx_sh_d & word_mask;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = 6'd0;
                        tx_sh_d    = tx_data_i;
                        tx_load_d  = 1'b1;
                        first_d    = 1'b1;
                    end else begin
                        bit_cnt_d = cnt_inc;
                    end
                end else if (drive_edge) begin
                    if (first_q) first_d = 1'b0;
                    else         tx_sh_d = tx_sh_q << 1;
                end
            end
            default: state_d = ST_ARM_WAIT;
        endcase
    end

    // State registers
    always_ff @(posedge GCLK) begin
        if (!RST) begin
            state_q     <= ST_ARM_WAIT;
            mode_q      <= 2'd0;
            len_q       <= 2'd0;
            tx_sh_q     <= 32'd0;
            rx_sh_q     <= 32'd0;
            bit_cnt_q   <= 6'd0;
            first_q     <= 1'b0;
            rx_data_q   <= 32'd0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - scoreboard bench for spi_slave_if with a behavioural SPI master
module tb_spi_slave_if;

    localparam int H = 6;

    logic        GCLK = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  spi_mode_i = 2'd0;
    logic [1:0]  word_len_i = 2'd0;
    logic [31:0] tx_data_i = 32'd0;
    logic        tx_load_o;
    logic [31:0] rx_data_o;
    logic        rx_valid_o;
    logic        frame_err_o;
    logic        busy_o;
    logic        SCLK_i = 1'b0;
    logic        CS_i = 1'b1;
    logic        MOSI_i = 1'b0;
    logic        MISO_o;

    spi_slave_if #(.SYNC_STAGES(2)) dut (
        .GCLK(GCLK), .RST(RST), .spi_mode_i(spi_mode_i), .word_len_i(word_len_i),
        .tx_data_i(tx_data_i), .tx_load_o(tx_load_o), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .frame_err_o(frame_err_o), .busy_o(busy_o),
        .SCLK_i(SCLK_i), .CS_i(CS_i), .MOSI_i(MOSI_i), .MISO_o(MISO_o)
    );

    always #5 GCLK = ~GCLK;

    int          n_tests = 0;
    int          n_fail = 0;
    int          load_cnt = 0;
    int          fe_cnt = 0;
    logic [31:0] exp_rx[$];
    logic [31:0] feed_q[$];
    logic [31:0] mosi_words[$];
    logic [31:0] tx_words[$];
    logic [31:0] last_rx_exp = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [1:0] l);
        longint unsigned m;
        m = (64'd1 << (8 * (int'(l) + 1))) - 64'd1;
        return m[31:0];
    endfunction

    // Monitor: scoreboard pops on rx_valid_o; counts loads/errors; feeds next tx word
    initial begin
        forever begin
            @(negedge GCLK);
            if (rx_valid_o) begin
                if (exp_rx.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                else check("rx_data", rx_data_o, exp_rx.pop_front());
            end
            if (tx_load_o) begin
                load_cnt++;
                if (feed_q.size() != 0) tx_data_i = feed_q.pop_front();
            end
            if (frame_err_o) fe_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge GCLK);
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [1:0] l);
        spi_mode_i = m;
        word_len_i = l;
        SCLK_i = m[1];
        wait_clk(4);
        CS_i = 1'b0;
        wait_clk(8);
    endtask

    task automatic end_frame();
        wait_clk(H);
        CS_i = 1'b1;
        wait_clk(12);
    endtask

    task automatic xfer_bit(input logic [1:0] m, input logic b, output logic miso);
        if (!m[0]) begin
            MOSI_i = b;
            wait_clk(H);
            miso = MISO_o;
            SCLK_i = ~m[1];
            wait_clk(H);
            SCLK_i = m[1];
        end else begin
            SCLK_i = ~m[1];
            MOSI_i = b;
            wait_clk(H);
            miso = MISO_o;
            SCLK_i = m[1];
            wait_clk(H);
        end
    endtask

    task automatic xfer_word(input logic [1:0] m, input logic [1:0] l,
                             input logic [31:0] w, output logic [31:0] got);
        logic b;
        int   n;
        n = 8 * (int'(l) + 1);
        got = 32'd0;
        for (int i = n - 1; i >= 0; i--) begin
            xfer_bit(m, w[i], b);
            got = {got[30:0], b};
        end
    endtask

    // One CS frame carrying mosi_words; the master should capture tx_words
    task automatic run_frame(input logic [1:0] m, input logic [1:0] l);
        logic [31:0] got;
        int          load0, fe0;
        load0 = load_cnt;
        fe0 = fe_cnt;
        tx_data_i = tx_words[0];
        feed_q.delete();
        for (int i = 1; i < tx_words.size(); i++) feed_q.push_back(tx_words[i]);
        start_frame(m, l);
        check("busy_active", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < mosi_words.size(); i++) begin
            exp_rx.push_back(mosi_words[i] & mask_of(l));
            last_rx_exp = mosi_words[i] & mask_of(l);
            xfer_word(m, l, mosi_words[i], got);
            check("miso_word", got, tx_words[i] & mask_of(l));
        end
        end_frame();
        check("tx_loads", 32'(load_cnt - load0), 32'(mosi_words.size() + 1));
        check("no_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("rx_drained", 32'(exp_rx.size()), 32'd0);
        check("busy_idle", {31'd0, busy_o}, 32'd0);
        check("miso_idle", {31'd0, MISO_o}, 32'd0);
        mosi_words.delete();
        tx_words.delete();
    endtask

    initial begin
        logic [31:0] got;
        logic        b;
        int          fe0, nw;
        logic [1:0]  m, l;

        // Reset state
        wait_clk(4);
        check("rst_rx_data", rx_data_o, 32'd0);
        check("rst_flags", {26'd0, rx_valid_o, tx_load_o, frame_err_o, busy_o, MISO_o, 1'b0}, 32'd0);
        RST = 1'b1;
        wait_clk(10);

        // 1: mode 0, 8 bits
        mosi_words.push_back(32'hA5); tx_words.push_back(32'h3C);
        run_frame(2'd0, 2'd0);
        // 2: mode 3, 32 bits
        mosi_words.push_back(32'hDEADBEEF); tx_words.push_back(32'h12345678);
        run_frame(2'd3, 2'd3);
        // 3: mode 1, 16 bits, two words in one frame, tx word changes after first load
        mosi_words.push_back(32'h1234); mosi_words.push_back(32'hABCD);
        tx_words.push_back(32'hCAFE);   tx_words.push_back(32'hBEEF);
        run_frame(2'd1, 2'd1);

        // 4: mode 2, CS raised after 5 SCLK cycles
        fe0 = fe_cnt;
        tx_data_i = 32'h55;
        start_frame(2'd2, 2'd0);
        for (int i = 0; i < 5; i++) xfer_bit(2'd2, 1'($urandom_range(0, 1)), b);
        end_frame();
        check("abort_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_rx_hold", rx_data_o, last_rx_exp);

        // 5: reset mid-word with CS held low, then a clean frame
        fe0 = fe_cnt;
        tx_data_i = 32'h0F;
        start_frame(2'd0, 2'd0);
        for (int i = 0; i < 4; i++) xfer_bit(2'd0, 1'b1, b);
        RST = 1'b0;
        wait_clk(2);
        RST = 1'b1;
        last_rx_exp = 32'd0;
        for (int i = 0; i < 4; i++) xfer_bit(2'd0, 1'b0, b);
        check("rstmid_busy", {31'd0, busy_o}, 32'd0);
        end_frame();
        check("rstmid_rx", rx_data_o, 32'd0);
        check("rstmid_no_err", 32'(fe_cnt - fe0), 32'd0);
        mosi_words.push_back(32'h5A); tx_words.push_back(32'hC3);
        run_frame(2'd0, 2'd0);

        // 6: word length change while busy takes effect on the next frame
        tx_data_i = 32'h96;
        feed_q.delete();
        exp_rx.push_back(32'h81);
        start_frame(2'd0, 2'd0);
        got = 32'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) word_len_i = 2'd3;
            xfer_bit(2'd0, ((32'h81 >> i) & 1) != 0, b);
            got = {got[30:0], b};
        end
        check("len_switch_miso", got, 32'h96);
        end_frame();
        check("len_switch_rx_drained", 32'(exp_rx.size()), 32'd0);
        mosi_words.push_back(32'h89ABCDEF); tx_words.push_back(32'h13579BDF);
        run_frame(2'd0, 2'd3);

        // Randomised frames over all modes, lengths and 1-3 words per frame
        for (int f = 0; f < 14; f++) begin
            m = 2'($urandom_range(0, 3));
            l = 2'($urandom_range(0, 3));
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) begin
                mosi_words.push_back($urandom);
                tx_words.push_back($urandom);
            end
            run_frame(m, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
